// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 80;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_ID_WD = 38;
   localparam int StallBus     = 6;
   localparam int STALL_WD     = StallBus;

   localparam int StallExMem = 3;
   localparam int StallMemWb = 4;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   typedef enum logic [3:0] {
      RD_NONE = 4'b0000,
      RD_LW   = 4'b1111,
      RD_LB   = 4'b0001,
      RD_LBU  = 4'b0010,
      RD_LH   = 4'b0011,
      RD_LHU  = 4'b0100,
      RD_SB   = 4'b0101,
      RD_SH   = 4'b0111
   } readen_e;

   typedef enum logic {
      LIVE = 1'b0,
      HELD = 1'b1
   } hold_state_e;

   typedef struct packed {
      logic [3:0]  readen;
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_mem_t;

   function automatic logic is_load_code(input logic [3:0] readen);
      logic res;
      res = 1'b0;
      case (readen)
         RD_LW, RD_LB, RD_LBU, RD_LH, RD_LHU: res = 1'b1;
         default:                             res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side bus bundle of the memory-access stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [StallBus-1:0]     stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
   logic                    mem_is_load;
   logic                    mem_adel;

   modport master (
      output stall, ex_to_mem_bus, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_id_bus, mem_is_load, mem_adel
   );

   modport slave (
      input  stall, ex_to_mem_bus, data_sram_rdata,
      output mem_to_wb_bus, mem_to_id_bus, mem_is_load, mem_adel
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/halfword of a loaded SRAM word.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]  readen_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] raw_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = raw_i[8*addr_i +: 8];
   assign half_lane = raw_i[16*addr_i[1] +: 16];

   // Odd halfword addresses have no defined lane and read back as zero.
   always_comb begin
      data_o = raw_i;
      case (readen_i)
         RD_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
         RD_LBU:  data_o = {24'h0, byte_lane};
         RD_LH:   data_o = addr_i[0] ? 32'h0 : {{16{half_lane[15]}}, half_lane};
         RD_LHU:  data_o = addr_i[0] ? 32'h0 : {16'h0, half_lane};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, stall-safe load data hold, load alignment.
// Define MEM_UNALIGNED_EXC_EN to flag misaligned lw/lh/lhu on mem_adel and suppress their write-back.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);

   ex_mem_t     ex_mem_q;
   ex_mem_t     ex_mem_d;
   hold_state_e state_q;
   logic [31:0] hold_q;

   logic        stall_ex_mem;
   logic        stall_mem_wb;
   logic        is_load;
   logic [31:0] raw_data;
   logic [31:0] aligned_data;
   logic [31:0] rf_wdata;
   logic        rf_we_out;
   logic        adel;

   assign stall_ex_mem = bus.stall[StallExMem];
   assign stall_mem_wb = bus.stall[StallMemWb];

   always_comb begin
      ex_mem_d = ex_mem_q;
      if (stall_ex_mem == NoStop) begin
         ex_mem_d = ex_mem_t'(bus.ex_to_mem_bus);
      end else if (stall_mem_wb == NoStop) begin
         ex_mem_d = '0;
      end
   end

   // SRAM data is only valid on a load's first MEM cycle; keep it while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem_q <= '0;
         state_q  <= LIVE;
         hold_q   <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
         case (state_q)
            LIVE: begin
               if (is_load && stall_ex_mem == Stop) begin
                  hold_q  <= bus.data_sram_rdata;
                  state_q <= HELD;
               end
            end
            HELD: begin
               if (stall_ex_mem == NoStop) begin
                  state_q <= LIVE;
               end
            end
            default: state_q <= LIVE;
         endcase
      end
   end

   assign is_load  = ex_mem_q.ram_en && is_load_code(ex_mem_q.readen);
   assign raw_data = (state_q == HELD) ? hold_q : bus.data_sram_rdata;

   mem_stage_load_align u_align (
      .readen_i (ex_mem_q.readen),
      .addr_i   (ex_mem_q.ex_result[1:0]),
      .raw_i    (raw_data),
      .data_o   (aligned_data)
   );

   assign rf_wdata = ex_mem_q.sel_rf_res ? aligned_data : ex_mem_q.ex_result;

`ifdef MEM_UNALIGNED_EXC_EN
   assign adel = is_load &&
                 (((ex_mem_q.readen == RD_LW) && (ex_mem_q.ex_result[1:0] != 2'b00)) ||
                  (((ex_mem_q.readen == RD_LH) || (ex_mem_q.readen == RD_LHU)) &&
                   ex_mem_q.ex_result[0]));
`else
   assign adel = 1'b0;
`endif

   assign rf_we_out = ex_mem_q.rf_we & ~adel;

   assign bus.mem_to_wb_bus = {ex_mem_q.pc, rf_we_out, ex_mem_q.rf_waddr, rf_wdata};
   assign bus.mem_to_id_bus = {rf_we_out, ex_mem_q.rf_waddr, rf_wdata};
   assign bus.mem_is_load   = is_load;
   assign bus.mem_adel      = adel;

   logic unused_bits;
   assign unused_bits = ^{ex_mem_q.ram_wen, bus.stall[5], bus.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases plus randomized traffic against a model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if bus_if ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [79:0] mk(input logic [3:0] rd, input logic [31:0] pc,
                                      input logic ram_en, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
      return {rd, pc, ram_en, 4'b0000, sel, we, wa, res};
   endfunction

   // Reference model: which instruction sits in MEM, and the SRAM word of its first MEM cycle.
   logic [79:0] m_reg   = '0;
   logic        m_first = 1'b1;
   logic [31:0] m_saved = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_reg   <= '0;
         m_first <= 1'b1;
         m_saved <= '0;
      end else begin
         if (m_first) m_saved <= bus_if.data_sram_rdata;
         if (!bus_if.stall[3]) begin
            m_reg   <= bus_if.ex_to_mem_bus;
            m_first <= 1'b1;
         end else if (!bus_if.stall[4]) begin
            m_reg   <= '0;
            m_first <= 1'b1;
         end else begin
            m_first <= 1'b0;
         end
      end
   end

   function automatic logic [31:0] exp_align(input logic [3:0] rd, input logic [1:0] a,
                                             input logic [31:0] raw);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = raw >> (8 * a);
      b  = sh[7:0];
      h  = sh[15:0];
      case (rd)
         4'b1111: return raw;
         4'b0001: return {{24{b[7]}}, b};
         4'b0010: return {24'h0, b};
         4'b0011: return a[0] ? 32'h0 : {{16{h[15]}}, h};
         4'b0100: return a[0] ? 32'h0 : {16'h0, h};
         default: return raw;
      endcase
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [3:0]  rd;
         logic [31:0] res, data, wd;
         logic        ld, adel, we;
         rd   = m_reg[79:76];
         res  = m_reg[31:0];
         ld   = m_reg[43] && (rd == 4'hF || rd == 4'h1 || rd == 4'h2 || rd == 4'h3 || rd == 4'h4);
         data = m_first ? bus_if.data_sram_rdata : m_saved;
         wd   = m_reg[38] ? exp_align(rd, res[1:0], data) : res;
`ifdef MEM_UNALIGNED_EXC_EN
         adel = ld && ((rd == 4'hF && res[1:0] != 2'b00) || ((rd == 4'h3 || rd == 4'h4) && res[0]));
`else
         adel = 1'b0;
`endif
         we = m_reg[37] && !adel;
         chk("model_wb_bus", bus_if.mem_to_wb_bus, {m_reg[75:44], we, m_reg[36:32], wd});
         chk("model_id_bus", bus_if.mem_to_id_bus, {32'h0, we, m_reg[36:32], wd});
         chk("model_is_load", bus_if.mem_is_load, ld);
         chk("model_adel", bus_if.mem_adel, adel);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] load_codes [5] = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4};

   initial begin
      rst = 1'b1;
      bus_if.stall = '0;
      bus_if.ex_to_mem_bus = '0;
      bus_if.data_sram_rdata = '0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("reset_wb_bus", bus_if.mem_to_wb_bus, 70'h0);
      chk("reset_id_bus", bus_if.mem_to_id_bus, 70'h0);
      chk("reset_is_load", bus_if.mem_is_load, 1'b0);
      chk("reset_adel", bus_if.mem_adel, 1'b0);
      rst = 1'b0;
      cmp_en = 1'b1;

      bus_if.ex_to_mem_bus = mk(RD_LB, 32'h400, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1000_0003);
      next_cycle();
      bus_if.data_sram_rdata = 32'h80AB_CDEF;
      bus_if.ex_to_mem_bus = mk(RD_LHU, 32'h404, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1000_0002);
      @(negedge clk);
      chk("lb_wdata", bus_if.mem_to_wb_bus[31:0], 32'hFFFF_FF80);
      chk("lb_we", bus_if.mem_to_wb_bus[37], 1'b1);
      chk("lb_waddr", bus_if.mem_to_wb_bus[36:32], 5'd5);

      next_cycle();
      bus_if.data_sram_rdata = 32'h9234_5678;
      bus_if.ex_to_mem_bus = mk(RD_LH, 32'h408, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1000_0000);
      @(negedge clk);
      chk("lhu_wdata", bus_if.mem_to_wb_bus[31:0], 32'h0000_9234);

      next_cycle();
      bus_if.ex_to_mem_bus = mk(RD_LW, 32'h40C, 1'b1, 1'b1, 1'b1, 5'd8, 32'h1000_0004);
      @(negedge clk);
      chk("lh_wdata", bus_if.mem_to_wb_bus[31:0], 32'h0000_5678);

      next_cycle();
      bus_if.data_sram_rdata = 32'hDEAD_BEEF;
      bus_if.stall = 6'b011000;
      bus_if.ex_to_mem_bus = mk(RD_NONE, 32'h410, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0042);
      @(negedge clk);
      chk("lw_stall_first", bus_if.mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         bus_if.data_sram_rdata = 32'h0;
         @(negedge clk);
         chk("lw_stall_held", bus_if.mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
      end
      next_cycle();
      bus_if.stall = '0;
      @(negedge clk);
      chk("lw_release", bus_if.mem_to_wb_bus[31:0], 32'hDEAD_BEEF);

      next_cycle();
      bus_if.stall = 6'b001000;
      @(negedge clk);
      chk("addu_id_bus", bus_if.mem_to_id_bus, {32'h0, 1'b1, 5'd9, 32'h0000_0042});

      next_cycle();
      bus_if.stall = '0;
      bus_if.ex_to_mem_bus = mk(RD_LW, 32'h414, 1'b1, 1'b1, 1'b1, 5'd10, 32'h1000_0008);
      @(negedge clk);
      chk("bubble_wb_bus", bus_if.mem_to_wb_bus, 70'h0);
      chk("bubble_is_load", bus_if.mem_is_load, 1'b0);

      next_cycle();
      bus_if.stall = 6'b011000;
      bus_if.data_sram_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("live_lw_is_load", bus_if.mem_is_load, 1'b1);
      chk("live_lw_wdata", bus_if.mem_to_wb_bus[31:0], 32'h1234_5678);

      next_cycle();
      rst = 1'b1;
      bus_if.data_sram_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("held_before_rst", bus_if.mem_to_wb_bus[31:0], 32'h1234_5678);

      next_cycle();
      rst = 1'b0;
      bus_if.stall = '0;
      bus_if.ex_to_mem_bus = mk(RD_LW, 32'h418, 1'b1, 1'b1, 1'b1, 5'd11, 32'h1000_0001);
      @(negedge clk);
      chk("rst_wb_bus", bus_if.mem_to_wb_bus, 70'h0);
      chk("rst_id_bus", bus_if.mem_to_id_bus, 70'h0);
      chk("rst_is_load", bus_if.mem_is_load, 1'b0);

      next_cycle();
      bus_if.data_sram_rdata = 32'hCAFE_F00D;
      bus_if.ex_to_mem_bus = '0;
      @(negedge clk);
`ifdef MEM_UNALIGNED_EXC_EN
      chk("misaligned_lw_adel", bus_if.mem_adel, 1'b1);
      chk("misaligned_lw_we", bus_if.mem_to_wb_bus[37], 1'b0);
`else
      chk("misaligned_lw_adel", bus_if.mem_adel, 1'b0);
      chk("misaligned_lw_we", bus_if.mem_to_wb_bus[37], 1'b1);
      chk("misaligned_lw_wdata", bus_if.mem_to_wb_bus[31:0], 32'hCAFE_F00D);
`endif

      for (int n = 0; n < 3000; n++) begin
         int kind;
         logic [3:0] rd;
         next_cycle();
         rst = ($urandom_range(0, 99) == 0);
         bus_if.stall = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b000000;
         bus_if.data_sram_rdata = $urandom;
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            rd = load_codes[$urandom_range(0, 4)];
            bus_if.ex_to_mem_bus = mk(rd, $urandom, 1'b1, 1'b1, 1'b1, 5'($urandom), $urandom);
         end else if (kind == 1) begin
            rd = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b0111;
            bus_if.ex_to_mem_bus = mk(rd, $urandom, 1'b1, 1'b0, 1'b0, 5'($urandom), $urandom);
         end else begin
            bus_if.ex_to_mem_bus = mk(4'b0000, $urandom, 1'b0, 1'b0, 1'b1, 5'($urandom), $urandom);
         end
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage and upstream of write-back.
- Registers the EX→MEM bus and returns load data from the synchronous data SRAM. It aligns and extends that data per load type and selects the write-back value.
- Drives the MEM→WB bus and the MEM→ID forwarding bus.
- Holds returned load data across pipeline stalls so a stalled load never loses its SRAM result.

Parameters:
- EX_TO_MEM_WD, 80, width of incoming EX→MEM bus
- MEM_TO_WB_WD, 70, width of outgoing MEM→WB bus
- STALL_WD, 6, width of the stall bus

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit 3 gates EX/MEM register, bit 4 gates MEM/WB; Stop=1
- ex_to_mem_bus  in  80  {readen[79:76], pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- data_sram_rdata  in  32  data SRAM read data, valid the cycle after the EX-stage request
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata} forwarding
- mem_is_load  out  1  registered instruction is a load (load-use hazard detect in ID)
- mem_adel  out  1  misaligned load detected (optional feature)

Behaviour:
- EX/MEM register:
  - rst → all zero.
  - stall[3]=Stop and stall[4]=NoStop → load zero (bubble).
  - stall[3]=NoStop → capture ex_to_mem_bus.
  - Otherwise hold.
- readen codes:
  - 0000 none
  - 1111 lw
  - 0001 lb
  - 0010 lbu
  - 0011 lh
  - 0100 lhu
  - 0101 sb
  - 0111 sh
- Load = readen ∈ {1111, 0001, 0010, 0011, 0100} and ram_en=1.
- mem_is_load is combinational from the registered bus.
- Hold FSM, states LIVE and HELD; reset → LIVE, hold_r=0:
  - LIVE: raw = data_sram_rdata. If load and stall[3]=Stop, capture hold_r ← data_sram_rdata and go to HELD.
  - HELD: raw = hold_r. Stay while stall[3]=Stop. Return to LIVE on stall[3]=NoStop (new instruction enters the same cycle; no capture that cycle).
  - rst in HELD → LIVE, hold_r=0, register zeroed.
- Alignment, with addr = ex_result[1:0]:
  - lw: raw.
  - lb/lbu: byte lane addr (00→[7:0] … 11→[31:24]), sign- or zero-extended.
  - lh/lhu: addr 00→[15:0], 10→[31:16], sign- or zero-extended.
  - lh/lhu with addr 01/11 → 0.
- rf_wdata = sel_rf_res ? aligned load data : ex_result.
- Stores and non-memory instructions pass ex_result through.
- Both output buses are combinational from the register and FSM, with no extra latency.
- All outputs are zero after rst.

Optional Feature:
- Macro MEM_UNALIGNED_EXC_EN.
- Defined:
  - lw with addr≠00, or lh/lhu with addr[0]=1, asserts mem_adel for the cycles the instruction sits in MEM.
  - Forces rf_we=0 on both output buses.
- Undefined:
  - mem_adel tied 0.
  - Misaligned loads write the aligned-rule result (0 for halfword, raw for lw).

Decomposition:
- Shared defines:
  - readen codes
  - EX_TO_MEM_WD, MEM_TO_WB_WD, StallBus
  - Stop/NoStop
  - FSM state encodings LIVE/HELD
- One natural sub-module: load_align (combinational; inputs readen, addr[1:0], raw[31:0]; output data[31:0]).

Test Plan:
- lb, ex_result=0x1000_0003, rdata=0x80AB_CDEF, sel_rf_res=1, rf_waddr=5 → rf_wdata=0xFFFF_FF80, rf_we=1, rf_waddr=5.
- lhu, addr=0x...02, rdata=0x9234_5678 → rf_wdata=0x0000_9234; lh, addr=0x...00 → 0x0000_5678.
- lw enters MEM with rdata=0xDEAD_BEEF; stall[3]=stall[4]=1 for 3 cycles while rdata changes to 0x0 → rf_wdata stays 0xDEAD_BEEF all stalled cycles; FSM returns to LIVE when stall clears.
- stall[3]=1, stall[4]=0 → next cycle mem_to_wb_bus=0 (bubble), mem_is_load=0.
- addu result 0x0000_0042, sel_rf_res=0 → rf_wdata=0x42 on mem_to_id_bus same cycle; rst asserted mid-HELD → all outputs 0 next cycle.
- With MEM_UNALIGNED_EXC_EN: lw, addr=0x...01 → mem_adel=1, rf_we=0; without the macro → mem_adel=0, rf_we=1.
